// File: rtl/nx_node_control_fanout.sv
// nx_node_control_fanout: stages node input updates, sequences logic-core runs
// and fans each changed core output out as signal messages taken from a
// per-output table held in the node RAM.
module nx_node_control_fanout #(
  parameter int unsigned INPUTS     = 32,
  parameter int unsigned OUTPUTS    = 32,
  parameter int unsigned MAX_FANOUT = 4,
  parameter int unsigned TGT_W      = 16,
  parameter int unsigned RAM_ADDR_W = 10,
  parameter int unsigned RAM_DATA_W = 32
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_trigger,
  output logic                      o_idle,
  input  logic [INPUTS-1:0]         i_loopback_mask,
  input  logic [$clog2(INPUTS)-1:0] i_input_index,
  input  logic                      i_input_value,
  input  logic                      i_input_is_seq,
  input  logic                      i_input_update,
  output logic                      o_core_trigger,
  input  logic                      i_core_idle,
  output logic [INPUTS-1:0]         o_core_inputs,
  input  logic [OUTPUTS-1:0]        i_core_outputs,
  output logic [RAM_ADDR_W-1:0]     o_ram_addr,
  output logic                      o_ram_rd_en,
  input  logic [RAM_DATA_W-1:0]     i_ram_rd_data,
  output logic [TGT_W-1:0]          o_msg_target,
  output logic [$clog2(INPUTS)-1:0] o_msg_index,
  output logic                      o_msg_value,
  output logic                      o_msg_is_seq,
  output logic                      o_msg_valid,
  input  logic                      i_msg_ready
);

  localparam int unsigned IW  = $clog2(INPUTS);
  localparam int unsigned OW  = $clog2(OUTPUTS + 1);
  localparam int unsigned OSW = (OUTPUTS > 1) ? $clog2(OUTPUTS) : 1;
  localparam int unsigned KW  = (MAX_FANOUT > 1) ? $clog2(MAX_FANOUT) : 1;
  localparam int unsigned LB  = (INPUTS < OUTPUTS) ? INPUTS : OUTPUTS;

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_WAIT, S_SCAN, S_LOOKUP, S_RESP, S_EMIT
  } state_t;

  state_t             state;
  logic [INPUTS-1:0]  r_next;
  logic [INPUTS-1:0]  r_current;
  logic [OUTPUTS-1:0] r_last_out;
  logic [OUTPUTS-1:0] cap_out;
  logic               trig_pend;
  logic               comb_pend;
  logic [OW-1:0]      o_idx;
  logic [KW-1:0]      k_idx;
  logic [OSW-1:0]     o_sel;

  logic start_c;
  logic comb_set_c;
  logic to_idle_c;
  logic trig_pend_n;
  logic comb_pend_n;
  logic idle_n;
  logic unused_in;

  assign o_core_inputs = r_current;
  assign o_sel         = o_idx[OSW-1:0];
  assign unused_in     = ^{i_ram_rd_data, i_loopback_mask};

  // Table entry address for output o, fan-out slot k.
  function automatic logic [RAM_ADDR_W-1:0] tbl_addr(input logic [OW-1:0] o,
                                                     input logic [KW-1:0] k);
    return RAM_ADDR_W'(32'(o) * 32'(MAX_FANOUT) + 32'(k));
  endfunction

  // Next-cycle pending flags and idle indication.
  always_comb begin
    comb_set_c  = i_input_update && !i_input_is_seq;
    start_c     = (state == S_IDLE) && (i_trigger || trig_pend || comb_pend);
    to_idle_c   = ((state == S_IDLE) && !start_c) ||
                  ((state == S_SCAN) && (o_idx == OW'(OUTPUTS)));
    trig_pend_n = trig_pend;
    comb_pend_n = comb_pend;
    if (start_c) begin
      trig_pend_n = 1'b0;
      comb_pend_n = 1'b0;
    end else if (i_trigger) begin
      trig_pend_n = 1'b1;
    end
    if (comb_set_c) comb_pend_n = 1'b1;
    idle_n = to_idle_c && !trig_pend_n && !comb_pend_n;
  end

  // Controller: run sequencing, change scan, table walk and message emission.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= S_IDLE;
      r_next         <= '0;
      r_current      <= '0;
      r_last_out     <= '0;
      cap_out        <= '0;
      trig_pend      <= 1'b0;
      comb_pend      <= 1'b0;
      o_idx          <= '0;
      k_idx          <= '0;
      o_idle         <= 1'b1;
      o_core_trigger <= 1'b0;
      o_ram_addr     <= '0;
      o_ram_rd_en    <= 1'b0;
      o_msg_target   <= '0;
      o_msg_index    <= '0;
      o_msg_value    <= 1'b0;
      o_msg_is_seq   <= 1'b0;
      o_msg_valid    <= 1'b0;
    end else begin
      o_core_trigger <= 1'b0;
      o_ram_rd_en    <= 1'b0;
      trig_pend      <= trig_pend_n;
      comb_pend      <= comb_pend_n;
      o_idle         <= idle_n;
      case (state)
        S_IDLE: begin
          if (start_c) begin
            r_current      <= r_next;
            o_core_trigger <= 1'b1;
            state          <= S_RUN;
          end
        end
        S_RUN: state <= S_WAIT;
        S_WAIT: begin
          if (i_core_idle) begin
            for (int unsigned i = 0; i < LB; i++) begin
              if (i_loopback_mask[i]) r_next[i] <= i_core_outputs[i];
            end
            cap_out <= i_core_outputs;
            o_idx   <= '0;
            state   <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (o_idx == OW'(OUTPUTS)) begin
            r_last_out <= cap_out;
            state      <= S_IDLE;
          end else if (cap_out[o_sel] == r_last_out[o_sel]) begin
            o_idx <= o_idx + OW'(1);
          end else begin
            k_idx       <= '0;
            o_ram_addr  <= tbl_addr(o_idx, '0);
            o_ram_rd_en <= 1'b1;
            state       <= S_LOOKUP;
          end
        end
        S_LOOKUP: state <= S_RESP;
        S_RESP: begin
          if (i_ram_rd_data[RAM_DATA_W-1]) begin
            o_msg_target <= i_ram_rd_data[TGT_W+IW:IW+1];
            o_msg_index  <= i_ram_rd_data[IW:1];
            o_msg_is_seq <= i_ram_rd_data[0];
            o_msg_value  <= cap_out[o_sel];
            o_msg_valid  <= 1'b1;
            state        <= S_EMIT;
          end else begin
            o_idx <= o_idx + OW'(1);
            state <= S_SCAN;
          end
        end
        S_EMIT: begin
          if (i_msg_ready) begin
            o_msg_valid <= 1'b0;
            if (k_idx == KW'(MAX_FANOUT - 1)) begin
              o_idx <= o_idx + OW'(1);
              state <= S_SCAN;
            end else begin
              k_idx       <= k_idx + KW'(1);
              o_ram_addr  <= tbl_addr(o_idx, k_idx + KW'(1));
              o_ram_rd_en <= 1'b1;
              state       <= S_LOOKUP;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
      // Decoder writes come last so they win over a same-cycle loopback.
      if (i_input_update) r_next[i_input_index] <= i_input_value;
    end
  end

endmodule

// File: tb/tb_nx_node_control_fanout.sv
// Bench for nx_node_control_fanout: directed scenarios plus randomized runs
// checked against a table-walk reference model and a RAM / ready model.
module tb_nx_node_control_fanout;

  logic        clk = 1'b0;
  logic        rst;
  logic        trigger;
  logic        o_idle;
  logic [31:0] loopback_mask;
  logic [4:0]  input_index;
  logic        input_value;
  logic        input_is_seq;
  logic        input_update;
  logic        core_trigger;
  logic        core_idle;
  logic [31:0] core_inputs;
  logic [31:0] core_outputs;
  logic [9:0]  ram_addr;
  logic        ram_rd_en;
  logic [31:0] ram_rd_data = 32'd0;
  logic [15:0] msg_target;
  logic [4:0]  msg_index;
  logic        msg_value;
  logic        msg_is_seq;
  logic        msg_valid;
  logic        msg_ready;

  int errors = 0;
  int checks = 0;

  // Reference state
  logic [31:0] m_next = 32'd0;
  logic [31:0] m_last = 32'd0;
  logic [31:0] ram [0:1023];
  logic [22:0] exp_q [$];
  logic [22:0] got_q [$];
  logic [9:0]  rd_q  [$];

  // Ready generator / monitors
  bit          rnd_mode = 1'b0;
  bit          rnd_bit  = 1'b1;
  int          stall_n  = 0;
  int          stall_cnt = 0;
  int          stall_seen = 0;
  int          stall_viol = 0;
  bit          held = 1'b0;
  logic [22:0] held_fields = 23'd0;
  logic [22:0] cur_fields;

  assign cur_fields = {msg_target, msg_index, msg_value, msg_is_seq};
  assign msg_ready  = rnd_mode ? rnd_bit : (stall_cnt >= stall_n);

  always #5 clk = ~clk;

  nx_node_control_fanout dut (
    .i_clk(clk), .i_rst(rst), .i_trigger(trigger), .o_idle(o_idle),
    .i_loopback_mask(loopback_mask), .i_input_index(input_index),
    .i_input_value(input_value), .i_input_is_seq(input_is_seq),
    .i_input_update(input_update), .o_core_trigger(core_trigger),
    .i_core_idle(core_idle), .o_core_inputs(core_inputs),
    .i_core_outputs(core_outputs), .o_ram_addr(ram_addr),
    .o_ram_rd_en(ram_rd_en), .i_ram_rd_data(ram_rd_data),
    .o_msg_target(msg_target), .o_msg_index(msg_index),
    .o_msg_value(msg_value), .o_msg_is_seq(msg_is_seq),
    .o_msg_valid(msg_valid), .i_msg_ready(msg_ready)
  );

  // Synchronous-read RAM model
  always @(posedge clk) if (ram_rd_en) ram_rd_data <= ram[ram_addr];

  // Ready stall counter and random ready source
  always @(posedge clk) begin
    if (rst || !msg_valid || msg_ready) stall_cnt <= 0;
    else stall_cnt <= stall_cnt + 1;
    rnd_bit <= 1'($urandom_range(0, 1));
  end

  // Handshake, RAM-read and stall-stability monitor
  always @(posedge clk) begin
    if (rst) begin
      held <= 1'b0;
    end else begin
      if (held && (msg_valid !== 1'b1 || cur_fields !== held_fields))
        stall_viol <= stall_viol + 1;
      held        <= msg_valid && !msg_ready;
      held_fields <= cur_fields;
      if (msg_valid && !msg_ready) stall_seen <= stall_seen + 1;
      if (msg_valid && msg_ready) got_q.push_back(cur_fields);
      if (ram_rd_en) rd_q.push_back(ram_addr);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_entry(input bit v, input logic [15:0] t,
                                           input logic [4:0] i, input bit s);
    return {v, 9'd0, t, i, s};
  endfunction

  // Expected messages: every changed output walks its table until an invalid entry.
  task automatic build_exp(input logic [31:0] nw);
    logic [31:0] e;
    exp_q.delete();
    for (int o = 0; o < 32; o++) begin
      if (nw[o] != m_last[o]) begin
        for (int k = 0; k < 4; k++) begin
          e = ram[o * 4 + k];
          if (!e[31]) break;
          exp_q.push_back({e[21:6], e[5:1], nw[o], e[0]});
        end
      end
    end
  endtask

  task automatic apply_update(input int idx, input bit val, input bit seq);
    input_index  = 5'(idx);
    input_value  = val;
    input_is_seq = seq;
    input_update = 1'b1;
    tick();
    input_update = 1'b0;
    m_next[idx]  = val;
  endtask

  task automatic wait_ctrig(input int budget, input string tag, output bit idle_seen);
    int n = 0;
    idle_seen = 1'b0;
    while (core_trigger !== 1'b1 && n < budget) begin
      tick();
      n++;
      if (o_idle === 1'b1) idle_seen = 1'b1;
    end
    chk({tag, "_core_trigger"}, 64'(core_trigger), 64'd1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (o_idle !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_idle_back"}, 64'(o_idle), 64'd1);
  endtask

  // Start a run (trigger or pending comb update) and check staged inputs.
  task automatic start_and_check(input bit use_trig, input string tag);
    bit dummy;
    got_q.delete();
    rd_q.delete();
    if (use_trig) begin
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      chk({tag, "_trig_latency"}, 64'(core_trigger), 64'd1);
    end else begin
      wait_ctrig(8, tag, dummy);
    end
    chk({tag, "_idle_low"}, 64'(o_idle), 64'd0);
    chk({tag, "_core_inputs"}, 64'(core_inputs), 64'(m_next));
  endtask

  // Present core results, then compare emitted messages with the model.
  task automatic complete(input logic [31:0] nw, input string tag);
    core_outputs = nw;
    build_exp(nw);
    for (int i = 0; i < 32; i++) if (loopback_mask[i]) m_next[i] = nw[i];
    wait_idle(5000, tag);
    chk({tag, "_msg_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_msg%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    m_last = nw;
  endtask

  initial begin
    bit          seen;
    int          s0;
    int          n;
    logic [31:0] nw;

    rst = 1'b1; trigger = 1'b0; loopback_mask = 32'd0;
    input_index = 5'd0; input_value = 1'b0; input_is_seq = 1'b0; input_update = 1'b0;
    core_idle = 1'b1; core_outputs = 32'd0;
    for (int a = 0; a < 1024; a++) ram[a] = 32'd0;

    // Reset state
    tick();
    tick();
    chk("rst_idle", 64'(o_idle), 64'd1);
    chk("rst_msg_valid", 64'(msg_valid), 64'd0);
    chk("rst_core_trigger", 64'(core_trigger), 64'd0);
    chk("rst_core_inputs", 64'(core_inputs), 64'd0);
    chk("rst_rd_en", 64'(ram_rd_en), 64'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_idle", 64'(o_idle), 64'd1);

    // Sequential update then trigger
    apply_update(3, 1'b1, 1'b1);
    tick();
    chk("seq_upd_no_run_idle", 64'(o_idle), 64'd1);
    chk("seq_upd_no_run_trig", 64'(core_trigger), 64'd0);
    start_and_check(1'b1, "t1");
    chk("t1_input3", 64'(core_inputs[3]), 64'd1);
    complete(32'd0, "t1");
    chk("t1_no_msg", 64'(got_q.size()), 64'd0);

    // Output 5 rises: one valid entry then an invalid one
    ram[20] = mk_entry(1'b1, 16'h0102, 5'd7, 1'b1);
    ram[21] = 32'd0;
    start_and_check(1'b1, "t2a");
    complete(32'h0000_0020, "t2a");
    if (got_q.size() > 0) chk("t2a_fields", 64'(got_q[0]), 64'({16'h0102, 5'd7, 1'b1, 1'b1}));
    start_and_check(1'b1, "t2b");
    complete(32'h0000_0020, "t2b");
    chk("t2b_no_msg", 64'(got_q.size()), 64'd0);

    // Output 2 with four valid entries and three stall cycles per message
    for (int k = 0; k < 4; k++) ram[8 + k] = mk_entry(1'b1, 16'hA000 + 16'(k), 5'(k + 1), k[0]);
    stall_n = 3;
    s0 = stall_seen;
    start_and_check(1'b1, "t3");
    complete(32'h0000_0024, "t3");
    chk("t3_rd_count", 64'(rd_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < rd_q.size(); i++)
      chk($sformatf("t3_rd_addr%0d", i), 64'(rd_q[i]), 64'(8 + i));
    chk("t3_stall_cycles", 64'(stall_seen - s0), 64'd12);
    chk("t3_stall_hold", 64'(stall_viol), 64'd0);
    stall_n = 0;

    // Combinational update in IDLE starts a run on its own
    apply_update(0, 1'b1, 1'b0);
    chk("t4_idle_low_after_comb", 64'(o_idle), 64'd0);
    start_and_check(1'b0, "t4a");
    complete(m_last, "t4a");

    // Combinational update during WAIT queues an immediate second run
    start_and_check(1'b1, "t4b");
    core_outputs = m_last;
    tick();
    input_index = 5'd0; input_value = ~m_next[0]; input_is_seq = 1'b0; input_update = 1'b1;
    m_next[0] = ~m_next[0];
    tick();
    input_update = 1'b0;
    got_q.delete();
    wait_ctrig(60, "t4c", seen);
    chk("t4c_no_idle_between", 64'(seen), 64'd0);
    chk("t4c_core_inputs", 64'(core_inputs), 64'(m_next));
    complete(m_last, "t4c");

    // Loopback of output 1, then decoder write in the capture cycle wins
    loopback_mask = 32'h0000_0002;
    start_and_check(1'b1, "t5a");
    complete(m_last | 32'h2, "t5a");
    start_and_check(1'b1, "t5b");
    chk("t5b_loopback_bit1", 64'(core_inputs[1]), 64'd1);
    core_outputs = m_last;
    tick();
    input_index = 5'd1; input_value = 1'b0; input_is_seq = 1'b1; input_update = 1'b1;
    tick();
    input_update = 1'b0;
    complete(m_last, "t5b");
    m_next[1] = 1'b0;
    start_and_check(1'b1, "t5c");
    chk("t5c_decoder_wins_bit1", 64'(core_inputs[1]), 64'd0);
    complete(m_last, "t5c");

    // Randomized runs with random tables, masks, updates and ready
    rnd_mode = 1'b1;
    for (int r = 0; r < 8; r++) begin
      for (int a = 0; a < 128; a++)
        ram[a] = ($urandom_range(0, 2) != 0) ?
                 mk_entry(1'b1, 16'($urandom), 5'($urandom), 1'($urandom)) : 32'd0;
      loopback_mask = $urandom;
      n = $urandom_range(0, 3);
      for (int u = 0; u < n; u++) apply_update($urandom_range(0, 31), 1'($urandom), 1'b1);
      nw = $urandom;
      if (r[0]) begin
        apply_update($urandom_range(0, 31), 1'($urandom), 1'b0);
        start_and_check(1'b0, $sformatf("rnd%0d", r));
      end else begin
        start_and_check(1'b1, $sformatf("rnd%0d", r));
      end
      complete(nw, $sformatf("rnd%0d", r));
    end
    chk("rnd_stall_hold", 64'(stall_viol), 64'd0);

    // Reset while a message is stalled in EMIT
    rnd_mode = 1'b0;
    stall_n = 5;
    for (int k = 0; k < 4; k++) ram[k] = mk_entry(1'b1, 16'h5500 + 16'(k), 5'(k), 1'b0);
    nw = m_last ^ 32'h1;
    start_and_check(1'b1, "t7");
    core_outputs = nw;
    n = 0;
    while (msg_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("t7_reached_emit", 64'(msg_valid), 64'd1);
    rst = 1'b1;
    tick();
    chk("t7_rst_msg_valid", 64'(msg_valid), 64'd0);
    chk("t7_rst_idle", 64'(o_idle), 64'd1);
    chk("t7_rst_core_inputs", 64'(core_inputs), 64'd0);
    rst = 1'b0;
    stall_n = 0;
    m_next = 32'd0;
    m_last = 32'd0;
    tick();
    start_and_check(1'b1, "t7_post");
    complete(nw, "t7_post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
